// File: rtl/qmult_scheduler.sv
// Round-robin front end that time-shares one sign-magnitude Q-format multiplier
// among NREQ requesters and returns each tagged product on a valid/ack port.
module qmult_scheduler #(
  parameter int Q    = 15,
  parameter int N    = 32,
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int SAT  = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ*N-1:0] i_multiplicand,
  input  logic [NREQ*N-1:0] i_multiplier,
  output logic [NREQ-1:0]   o_gnt,
  output logic [N-1:0]      o_result,
  output logic              o_ovr,
  output logic [IDW-1:0]    o_id,
  output logic              o_valid,
  input  logic              i_ack
);

  typedef enum logic [1:0] {IDLE, MUL, PACK, RESP} state_t;

  state_t              state, state_next;
  logic [IDW-1:0]      ptr, ptr_next, winner, id_q;
  logic [IDW:0]        cand;
  logic                found;
  logic [N-1:0]        sel_a, sel_b;
  logic [N-2:0]        a_mag, b_mag;
  logic                sign_q;
  logic [2*N-3:0]      prod;
  logic [2*N-3-Q:0]    prod_hi;
  logic [N-2:0]        pack_mag;
  logic                pack_ovr;

  // First requesting index at or after ptr, wrapping modulo NREQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!found && i_req[cand[IDW-1:0]]) begin
        found  = 1'b1;
        winner = cand[IDW-1:0];
      end
    end
  end

  assign ptr_next = (winner == IDW'(NREQ-1)) ? '0 : winner + 1'b1;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (winner == IDW'(k)) begin
        sel_a = i_multiplicand[k*N +: N];
        sel_b = i_multiplier[k*N +: N];
      end
    end
  end

  // Product shifted down by Q: low N-1 bits are the kept magnitude, the rest signal overflow.
  assign prod_hi  = (2*N-2-Q)'(prod >> Q);
  assign pack_ovr = |prod_hi[2*N-3-Q:N-1];
  assign pack_mag = ((SAT != 0) && pack_ovr) ? '1 : prod_hi[N-2:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  // Grant is suppressed while reset is held so nothing is offered mid-reset.
  always_comb begin
    state_next = state;
    o_gnt      = '0;
    case (state)
      IDLE: begin
        if (found && !i_rst) begin
          o_gnt      = NREQ'(1) << winner;
          state_next = MUL;
        end
      end
      MUL:     state_next = PACK;
      PACK:    state_next = RESP;
      RESP:    if (i_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr      <= '0;
      id_q     <= '0;
      a_mag    <= '0;
      b_mag    <= '0;
      sign_q   <= 1'b0;
      prod     <= '0;
      o_result <= '0;
      o_ovr    <= 1'b0;
      o_id     <= '0;
      o_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            ptr    <= ptr_next;
            id_q   <= winner;
            a_mag  <= sel_a[N-2:0];
            b_mag  <= sel_b[N-2:0];
            sign_q <= sel_a[N-1] ^ sel_b[N-1];
          end
        end
        MUL: prod <= {{(N-1){1'b0}}, a_mag} * {{(N-1){1'b0}}, b_mag};
        PACK: begin
          o_result <= {sign_q, pack_mag};
          o_ovr    <= pack_ovr;
          o_id     <= id_q;
          o_valid  <= 1'b1;
        end
        RESP: if (i_ack) o_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qmult_scheduler.sv
// Randomised bench for qmult_scheduler: a truncating and a saturating instance
// share stimulus and are compared against an arithmetic reference model.
module tb_qmult_scheduler;
  localparam int N = 32, Q = 15, NREQ = 4, IDW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] mcand, mplier;
  logic              ack;
  logic [NREQ-1:0]   gnt, gnt_s;
  logic [N-1:0]      result, result_s;
  logic              ovr, ovr_s, valid, valid_s;
  logic [IDW-1:0]    id, id_s;

  int checks = 0;
  int failures = 0;
  int ptr_model = 0;
  logic [N-1:0] opa [NREQ];
  logic [N-1:0] opb [NREQ];

  always #5 clk = ~clk;

  qmult_scheduler #(.Q(Q), .N(N), .NREQ(NREQ), .IDW(IDW), .SAT(0)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_multiplicand(mcand), .i_multiplier(mplier),
    .o_gnt(gnt), .o_result(result), .o_ovr(ovr), .o_id(id), .o_valid(valid), .i_ack(ack));

  qmult_scheduler #(.Q(Q), .N(N), .NREQ(NREQ), .IDW(IDW), .SAT(1)) dut_sat (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_multiplicand(mcand), .i_multiplier(mplier),
    .o_gnt(gnt_s), .o_result(result_s), .o_ovr(ovr_s), .o_id(id_s), .o_valid(valid_s), .i_ack(ack));

  // Reference: full-precision product of magnitudes, divided by 2^Q, checked against the N-1 bit range.
  function automatic logic [N:0] model_mul(input logic [N-1:0] a, input logic [N-1:0] b, input bit sat);
    longint unsigned ma, mb, q;
    logic [N-1:0] r;
    bit o;
    ma = 64'(a[N-2:0]);
    mb = 64'(b[N-2:0]);
    q = (ma * mb) >> Q;
    o = (q > 64'h7FFF_FFFF);
    r[N-1] = a[N-1] ^ b[N-1];
    r[N-2:0] = (o && sat) ? 31'h7FFF_FFFF : q[30:0];
    return {o, r};
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] m, input int p);
    int k;
    for (int i = 0; i < NREQ; i++) begin
      k = (p + i) % NREQ;
      if (m[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int k);
    return (k < 0) ? '0 : (NREQ'(1) << k);
  endfunction

  task automatic set_ops(input int k, input logic [N-1:0] a, input logic [N-1:0] b);
    opa[k] = a;
    opb[k] = b;
    mcand[k*N +: N] = a;
    mplier[k*N +: N] = b;
  endtask

  task automatic randomize_ops();
    logic [N-1:0] a, b;
    for (int k = 0; k < NREQ; k++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 2) != 0) a[N-2:0] = a[N-2:0] >> $urandom_range(8, 24);
      if ($urandom_range(0, 2) != 0) b[N-2:0] = b[N-2:0] >> $urandom_range(8, 24);
      if ($urandom_range(0, 7) == 0) a[N-2:0] = '0;
      set_ops(k, a, b);
    end
  endtask

  // Issues one job for mask, drops req after the grant, waits for valid, acks once.
  task automatic launch(input logic [NREQ-1:0] mask, output logic [NREQ-1:0] g, output int lat,
                        output logic [N-1:0] r, output logic ov, output logic [IDW-1:0] idv,
                        output logic [N-1:0] rs, output logic ovs, output logic va);
    @(negedge clk);
    req = mask;
    ack = 1'b0;
    #1 g = gnt;
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      req = '0;
      #1;
      if (valid) begin
        lat = c;
        break;
      end
    end
    r = result; ov = ovr; idv = id; rs = result_s; ovs = ovr_s;
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    #1 va = valid;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '1; ack = 1'b0; mcand = '0; mplier = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (result !== '0) begin failures++; $display("[TB] FAIL reset_result got=%h exp=0", result); end
    checks++; if (id !== '0 || ovr !== 1'b0) begin failures++; $display("[TB] FAIL reset_id_ovr got=%0d/%b exp=0/0", id, ovr); end
    checks++; if (gnt !== '0) begin failures++; $display("[TB] FAIL reset_gnt got=%b exp=0000", gnt); end
    @(negedge clk);
    rst = 1'b0; req = '0; ptr_model = 0;
    for (int c = 0; c < 3; c++) begin
      ack = 1'b1;
      #1;
      checks++; if (gnt !== '0 || valid !== 1'b0) begin failures++; $display("[TB] FAIL idle_quiet got=%b/%b exp=0000/0", gnt, valid); end
      @(negedge clk);
    end
    ack = 1'b0;
  endtask

  task automatic test_basic();
    logic [NREQ-1:0] g; int lat; logic [N-1:0] r, rs; logic ov, ovs, va; logic [IDW-1:0] idv;
    set_ops(2, 32'h0000C000, 32'h00010000);
    launch(4'b0100, g, lat, r, ov, idv, rs, ovs, va);
    ptr_model = 3;
    checks++; if (g !== 4'b0100) begin failures++; $display("[TB] FAIL basic_gnt got=%b exp=0100", g); end
    checks++; if (lat !== 3) begin failures++; $display("[TB] FAIL basic_latency got=%0d exp=3", lat); end
    checks++; if (r !== 32'h00018000 || ov !== 1'b0) begin failures++; $display("[TB] FAIL basic_result got=%h/%b exp=00018000/0", r, ov); end
    checks++; if (idv !== 2'd2) begin failures++; $display("[TB] FAIL basic_id got=%0d exp=2", idv); end
    checks++; if (va !== 1'b0) begin failures++; $display("[TB] FAIL basic_ack_drop got=%b exp=0", va); end
  endtask

  task automatic test_sign();
    logic [NREQ-1:0] g; int lat; logic [N-1:0] r, rs; logic ov, ovs, va; logic [IDW-1:0] idv;
    set_ops(2, 32'h8000C000, 32'h00010000);
    launch(4'b0100, g, lat, r, ov, idv, rs, ovs, va);
    checks++; if (r !== 32'h80018000 || ov !== 1'b0) begin failures++; $display("[TB] FAIL sign_neg got=%h/%b exp=80018000/0", r, ov); end
    set_ops(2, 32'h80000000, 32'h00008000);
    launch(4'b0100, g, lat, r, ov, idv, rs, ovs, va);
    checks++; if (r !== 32'h80000000 || rs !== 32'h80000000) begin failures++; $display("[TB] FAIL sign_negzero got=%h/%h exp=80000000", r, rs); end
  endtask

  task automatic test_overflow();
    logic [NREQ-1:0] g; int lat; logic [N-1:0] r, rs; logic ov, ovs, va; logic [IDW-1:0] idv;
    set_ops(2, 32'h40000000, 32'h00010000);
    launch(4'b0100, g, lat, r, ov, idv, rs, ovs, va);
    checks++; if (r !== 32'h00000000 || ov !== 1'b1) begin failures++; $display("[TB] FAIL ovf_trunc got=%h/%b exp=00000000/1", r, ov); end
    checks++; if (rs !== 32'h7FFFFFFF || ovs !== 1'b1) begin failures++; $display("[TB] FAIL ovf_sat got=%h/%b exp=7fffffff/1", rs, ovs); end
  endtask

  // Holds pattern with ack tied high until ngrants grants, then drains outstanding results.
  task automatic run_sched(input logic [NREQ-1:0] pattern, input int ngrants, output int seen);
    int grants, last, k;
    int idq[$];
    int cycq[$];
    logic [N:0] e;
    grants = 0; last = -1; seen = 0;
    req = pattern; ack = 1'b1;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (valid) begin
        if (idq.size() == 0) begin
          checks++; failures++; $display("[TB] FAIL rr_spurious_valid got=1 exp=0");
        end else begin
          k = idq.pop_front();
          e = model_mul(opa[k], opb[k], 1'b0);
          checks++; if (id !== IDW'(k) || result !== e[N-1:0]) begin failures++; $display("[TB] FAIL rr_result id got=%0d exp=%0d res got=%h exp=%h", id, k, result, e[N-1:0]); end
          checks++; if (c - cycq.pop_front() != 3) begin failures++; $display("[TB] FAIL rr_latency got=other exp=3"); end
          seen++;
        end
      end
      if (gnt !== '0) begin
        k = rr_pick(req, ptr_model);
        checks++; if (gnt !== onehot(k)) begin failures++; $display("[TB] FAIL rr_gnt got=%b exp=%b", gnt, onehot(k)); end
        if (last >= 0) begin
          checks++; if (c - last != 4) begin failures++; $display("[TB] FAIL rr_spacing got=%0d exp=4", c - last); end
        end
        last = c;
        if (k >= 0) begin
          idq.push_back(k);
          cycq.push_back(c);
          ptr_model = (k + 1) % NREQ;
        end
        grants++;
      end
      if (grants >= ngrants && idq.size() == 0) break;
      @(negedge clk);
      if (grants >= ngrants) req = '0;
    end
    checks++; if (grants != ngrants || seen != ngrants) begin failures++; $display("[TB] FAIL rr_count grants got=%0d results got=%0d exp=%0d", grants, seen, ngrants); end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int seen;
    @(negedge clk);
    rst = 1'b1; req = '0;
    randomize_ops();
    @(negedge clk);
    rst = 1'b0; ptr_model = 0;
    run_sched(4'b1111, 5, seen);
    run_sched(4'b1010, 3, seen);
  endtask

  task automatic test_back_to_back();
    logic [N:0] e;
    logic [N-1:0] snap;
    logic [NREQ-1:0] r2;
    int k, k2, seen;
    randomize_ops();
    @(negedge clk);
    req = 4'b0001; ack = 1'b0;
    k = rr_pick(req, ptr_model);
    #1;
    checks++; if (gnt !== onehot(k)) begin failures++; $display("[TB] FAIL bp_gnt got=%b exp=%b", gnt, onehot(k)); end
    ptr_model = (k + 1) % NREQ;
    @(negedge clk); req = '0; ack = 1'b1;
    @(negedge clk); ack = 1'b1;
    @(negedge clk); ack = 1'b0;
    #1;
    e = model_mul(opa[k], opb[k], 1'b0);
    snap = result;
    checks++; if (valid !== 1'b1 || result !== e[N-1:0]) begin failures++; $display("[TB] FAIL bp_first got=%b/%h exp=1/%h", valid, result, e[N-1:0]); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req = NREQ'($urandom_range(1, 15));
      #1;
      checks++; if (valid !== 1'b1 || result !== snap || id !== IDW'(k) || gnt !== '0) begin
        failures++; $display("[TB] FAIL bp_hold valid=%b res got=%h exp=%h id got=%0d exp=%0d gnt got=%b exp=0000", valid, result, snap, id, k, gnt);
      end
    end
    @(negedge clk);
    r2 = NREQ'($urandom_range(1, 15));
    req = r2; ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    #1;
    k2 = rr_pick(r2, ptr_model);
    checks++; if (valid !== 1'b0 || gnt !== onehot(k2)) begin failures++; $display("[TB] FAIL bp_release valid got=%b exp=0 gnt got=%b exp=%b", valid, gnt, onehot(k2)); end
    ptr_model = (k2 + 1) % NREQ;
    seen = 0;
    e = model_mul(opa[k2], opb[k2], 1'b0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      req = '0; ack = 1'b1;
      #1;
      if (valid) begin
        seen++;
        checks++; if (id !== IDW'(k2) || result !== e[N-1:0]) begin failures++; $display("[TB] FAIL bp_next id got=%0d exp=%0d res got=%h exp=%h", id, k2, result, e[N-1:0]); end
      end
    end
    checks++; if (seen != 1) begin failures++; $display("[TB] FAIL bp_next_count got=%0d exp=1", seen); end
    ack = 1'b0;
  endtask

  task automatic test_reset_in_resp();
    int waited;
    set_ops(1, 32'h00012345, 32'h00020000);
    @(negedge clk);
    req = 4'b0010; ack = 1'b0;
    @(negedge clk);
    req = '0;
    waited = 0;
    #1;
    while (!valid && waited < 8) begin
      @(negedge clk);
      #1 waited++;
    end
    checks++; if (valid !== 1'b1 || id !== 2'd1) begin failures++; $display("[TB] FAIL rstresp_pre valid got=%b id got=%0d exp=1/1", valid, id); end
    #2 rst = 1'b1;
    #1;
    checks++; if (valid !== 1'b0 || result !== '0 || id !== '0 || ovr !== 1'b0) begin
      failures++; $display("[TB] FAIL rstresp_async valid=%b res=%h id=%0d ovr=%b exp=0", valid, result, id, ovr);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    req = 4'b0100;
    @(negedge clk);
    req = '0;
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; ptr_model = 0;
    waited = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1 if (valid) waited++;
    end
    checks++; if (waited != 0) begin failures++; $display("[TB] FAIL rst_discard valid_cycles got=%0d exp=0", waited); end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] g, mask; int lat, k; logic [N-1:0] r, rs; logic ov, ovs, va; logic [IDW-1:0] idv;
    logic [N:0] e, es;
    for (int it = 0; it < 20; it++) begin
      randomize_ops();
      mask = NREQ'($urandom_range(1, 15));
      k = rr_pick(mask, ptr_model);
      launch(mask, g, lat, r, ov, idv, rs, ovs, va);
      ptr_model = (k + 1) % NREQ;
      e = model_mul(opa[k], opb[k], 1'b0);
      es = model_mul(opa[k], opb[k], 1'b1);
      checks++; if (g !== onehot(k) || lat !== 3 || idv !== IDW'(k) || va !== 1'b0) begin
        failures++; $display("[TB] FAIL rand_ctrl gnt got=%b exp=%b lat got=%0d exp=3 id got=%0d exp=%0d drop=%b", g, onehot(k), lat, idv, k, va);
      end
      checks++; if ({ov, r} !== e) begin failures++; $display("[TB] FAIL rand_trunc got=%b/%h exp=%b/%h", ov, r, e[N], e[N-1:0]); end
      checks++; if ({ovs, rs} !== es) begin failures++; $display("[TB] FAIL rand_sat got=%b/%h exp=%b/%h", ovs, rs, es[N], es[N-1:0]); end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_sign();
    test_overflow();
    test_round_robin();
    test_back_to_back();
    test_reset_in_resp();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
